// File: rtl/ctrl_seq_pkg.sv
// rtl/ctrl_seq_pkg.sv - shared states, opcodes, console modes and ALU encodings for ctrl_seq_unit
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CONS,
    ST_RUN,
    ST_HALT,
    ST_INTA
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_INC  = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_JC   = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_OUT  = 4'hA;
  localparam logic [3:0] OP_OR   = 4'hB;
  localparam logic [3:0] OP_XOR  = 4'hC;
  localparam logic [3:0] OP_NOP2 = 4'hD;
  localparam logic [3:0] OP_STP  = 4'hE;
  localparam logic [3:0] OP_EI   = 4'hF;

  localparam logic [2:0] MD_RUN  = 3'b000;
  localparam logic [2:0] MD_WMEM = 3'b001;
  localparam logic [2:0] MD_RMEM = 3'b010;
  localparam logic [2:0] MD_RREG = 3'b011;
  localparam logic [2:0] MD_WREG = 3'b100;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
    logic       cin;
  } alu_t;

  typedef struct packed {
    logic ldz, ldc, cin, m, drw, abus, sbus, mbus;
    logic pcinc, pcadd, lpc, lar, arinc, memw, lir, selctl;
  } ctl_t;

  // ALU setting used in the first beat of each opcode; zero for opcodes that leave the ALU idle
  function automatic alu_t alu_code(input logic [3:0] op);
    alu_t a;
    a = '0;
    case (op)
      OP_ADD:         a = {4'b1001, 1'b0, 1'b1};
      OP_SUB:         a = {4'b0110, 1'b0, 1'b0};
      OP_AND:         a = {4'b1011, 1'b1, 1'b0};
      OP_INC:         a = {4'b0000, 1'b0, 1'b0};
      OP_OR:          a = {4'b1110, 1'b1, 1'b0};
      OP_XOR:         a = {4'b0110, 1'b1, 1'b0};
      OP_OUT, OP_LD:  a = {4'b1010, 1'b1, 1'b0};
      OP_JMP, OP_ST:  a = {4'b1111, 1'b1, 1'b0};
      default:        a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/ctrl_seq_unit_beat_gen.sv
// rtl/ctrl_seq_unit_beat_gen.sv - one-hot beat counter, returns to W1 after the last beat
module ctrl_beat_gen #(
  parameter int NBEAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             last,
  output logic [NBEAT-1:0] beat
);

  localparam logic [NBEAT-1:0] W1 = NBEAT'(1);

  // only W1..W3 are ever used, so the third beat always wraps
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)
      beat <= W1;
    else if (last || beat[2])
      beat <= W1;
    else
      beat <= beat << 1;
  end

endmodule

// File: rtl/ctrl_seq_unit.sv
// rtl/ctrl_seq_unit.sv - hardwired teaching-CPU controller with internal beat sequencer,
// console modes, single-step, halt/resume and one-level interrupt acknowledge
module ctrl_seq_unit
  import ctrl_seq_pkg::*;
#(
  parameter int REGW  = 2,
  parameter int NBEAT = 3
) (
  input  logic              T3,
  input  logic              CLR,
  input  logic [2:0]        SW,
  input  logic              START,
  input  logic              SSTEP,
  input  logic              INTR,
  input  logic [3:0]        IR,
  input  logic              C,
  input  logic              Z,
  output logic [NBEAT-1:0]  W,
  output logic              LDZ, LDC, CIN, M, DRW, ABUS, SBUS, MBUS,
  output logic              PCINC, PCADD, LPC, LAR, ARINC, MEMW, LIR, SELCTL,
  output logic [3:0]        S,
  output logic [2*REGW-1:0] SEL,
  output logic              STOP,
  output logic              INTA
);

  localparam logic [NBEAT-1:0] W1   = NBEAT'(1);
  localparam logic [REGW-1:0]  RONE = REGW'(1);
  localparam logic [REGW-1:0]  RTWO = REGW'(2);

  state_t           state;
  logic [2:0]       mode;
  logic             ie;
  logic [REGW-1:0]  ridx;
  logic [NBEAT-1:0] beat;

  ctl_t ctl;
  alu_t alu;
  logic adv;
  logic halt_req;

  ctrl_beat_gen #(.NBEAT(NBEAT)) u_beat (
    .clk   (T3),
    .rst_n (CLR),
    .last  (!adv),
    .beat  (beat)
  );

  assign {LDZ, LDC, CIN, M, DRW, ABUS, SBUS, MBUS,
          PCINC, PCADD, LPC, LAR, ARINC, MEMW, LIR, SELCTL} = ctl;

  always_comb begin
    ctl      = '0;
    alu      = '0;
    S        = '0;
    SEL      = '0;
    W        = '0;
    STOP     = 1'b0;
    INTA     = 1'b0;
    adv      = 1'b0;
    halt_req = 1'b0;
    case (state)
      ST_IDLE: STOP = 1'b1;
      ST_SETUP: begin
        W = beat;
        if (mode == MD_RUN) begin
          if (beat[0]) begin
            ctl.sbus = 1'b1; ctl.lpc = 1'b1; ctl.selctl = 1'b1;
            adv = 1'b1;
          end else begin
            ctl.lir = 1'b1; ctl.pcinc = 1'b1;
          end
        end else begin
          ctl.sbus = 1'b1; ctl.lar = 1'b1; ctl.selctl = 1'b1;
        end
      end
      ST_CONS: begin
        STOP = 1'b1;
        W    = W1;
        // a console op only fires on the START edge whose switches still match the latched mode
        if (START && SW == mode) begin
          case (mode)
            MD_WMEM: begin ctl.sbus = 1'b1; ctl.memw = 1'b1; ctl.arinc = 1'b1; end
            MD_RMEM: begin ctl.mbus = 1'b1; ctl.arinc = 1'b1; end
            MD_RREG: begin ctl.selctl = 1'b1; SEL = {ridx, ridx + RONE}; end
            MD_WREG: begin
              ctl.sbus = 1'b1; ctl.drw = 1'b1; ctl.selctl = 1'b1;
              SEL = {ridx, ridx};
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        W = beat;
        if (beat[0]) begin
          alu     = alu_code(IR);
          S       = alu.s;
          ctl.m   = alu.m;
          ctl.cin = alu.cin;
          case (IR)
            OP_ADD, OP_SUB, OP_INC: begin
              ctl.abus = 1'b1; ctl.drw = 1'b1; ctl.ldz = 1'b1; ctl.ldc = 1'b1;
              ctl.lir = 1'b1; ctl.pcinc = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
              ctl.abus = 1'b1; ctl.drw = 1'b1; ctl.ldz = 1'b1;
              ctl.lir = 1'b1; ctl.pcinc = 1'b1;
            end
            OP_OUT: begin ctl.abus = 1'b1; ctl.lir = 1'b1; ctl.pcinc = 1'b1; end
            OP_JMP: begin ctl.abus = 1'b1; ctl.lpc = 1'b1; adv = 1'b1; end
            OP_LD, OP_ST: begin ctl.abus = 1'b1; ctl.lar = 1'b1; adv = 1'b1; end
            OP_JC: begin
              if (C) begin ctl.pcadd = 1'b1; adv = 1'b1; end
              else begin ctl.lir = 1'b1; ctl.pcinc = 1'b1; end
            end
            OP_JZ: begin
              if (Z) begin ctl.pcadd = 1'b1; adv = 1'b1; end
              else begin ctl.lir = 1'b1; ctl.pcinc = 1'b1; end
            end
            OP_STP: begin STOP = 1'b1; halt_req = 1'b1; end
            default: begin ctl.lir = 1'b1; ctl.pcinc = 1'b1; end
          endcase
        end else begin
          ctl.lir = 1'b1; ctl.pcinc = 1'b1;
          if (IR == OP_LD) begin
            ctl.mbus = 1'b1; ctl.drw = 1'b1;
          end else if (IR == OP_ST) begin
            S = 4'b1010; ctl.m = 1'b1; ctl.abus = 1'b1; ctl.memw = 1'b1;
          end
        end
      end
      ST_HALT: STOP = 1'b1;
      ST_INTA: begin
        W = beat;
        if (beat[0]) begin
          INTA = 1'b1; ctl.lpc = 1'b1;
          adv = 1'b1;
        end else begin
          ctl.lir = 1'b1; ctl.pcinc = 1'b1;
        end
      end
      default: STOP = 1'b1;
    endcase
  end

  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      state <= ST_IDLE;
      mode  <= '0;
      ie    <= 1'b0;
      ridx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            mode <= SW;
            case (SW)
              MD_RUN, MD_WMEM, MD_RMEM: state <= ST_SETUP;
              MD_RREG, MD_WREG: begin state <= ST_CONS; ridx <= '0; end
              default: ;
            endcase
          end
        end
        ST_SETUP: if (!adv) state <= (mode == MD_RUN) ? ST_RUN : ST_CONS;
        ST_CONS: begin
          if (START) begin
            if (SW != mode)         state <= ST_IDLE;
            else if (mode == MD_RREG) ridx <= ridx + RTWO;
            else if (mode == MD_WREG) ridx <= ridx + RONE;
          end
        end
        ST_RUN: begin
          // LIR marks the final beat: this edge is the instruction boundary
          if (halt_req) begin
            state <= ST_HALT;
          end else if (ctl.lir) begin
            if (beat[0] && IR == OP_EI) ie <= 1'b1;
            if (SSTEP)            state <= ST_HALT;
            else if (INTR && ie)  state <= ST_INTA;
            else                  state <= ST_RUN;
          end
        end
        ST_HALT: if (START) state <= ST_RUN;
        ST_INTA: begin
          if (beat[0]) ie <= 1'b0;
          else         state <= ST_RUN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// tb/tb_ctrl_seq_unit.sv - self-checking bench for ctrl_seq_unit against an instruction-level model
module tb_ctrl_seq_unit;

  localparam int REGW  = 2;
  localparam int NBEAT = 3;

  logic T3 = 1'b1;
  logic CLR, START, SSTEP, INTR, C, Z;
  logic [2:0] SW;
  logic [3:0] IR;
  logic [NBEAT-1:0] W;
  logic LDZ, LDC, CIN, M, DRW, ABUS, SBUS, MBUS;
  logic PCINC, PCADD, LPC, LAR, ARINC, MEMW, LIR, SELCTL;
  logic [3:0] S;
  logic [2*REGW-1:0] SEL;
  logic STOP, INTA;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] B_LDZ = 16'h8000, B_LDC = 16'h4000, B_CIN = 16'h2000, B_M = 16'h1000;
  localparam logic [15:0] B_DRW = 16'h0800, B_ABUS = 16'h0400, B_SBUS = 16'h0200, B_MBUS = 16'h0100;
  localparam logic [15:0] B_PCINC = 16'h0080, B_PCADD = 16'h0040, B_LPC = 16'h0020, B_LAR = 16'h0010;
  localparam logic [15:0] B_ARINC = 16'h0008, B_MEMW = 16'h0004, B_LIR = 16'h0002, B_SELCTL = 16'h0001;
  localparam logic [15:0] FETCH = B_LIR | B_PCINC;

  ctrl_seq_unit #(.REGW(REGW), .NBEAT(NBEAT)) dut (
    .T3(T3), .CLR(CLR), .SW(SW), .START(START), .SSTEP(SSTEP), .INTR(INTR),
    .IR(IR), .C(C), .Z(Z), .W(W),
    .LDZ(LDZ), .LDC(LDC), .CIN(CIN), .M(M), .DRW(DRW), .ABUS(ABUS), .SBUS(SBUS), .MBUS(MBUS),
    .PCINC(PCINC), .PCADD(PCADD), .LPC(LPC), .LAR(LAR), .ARINC(ARINC), .MEMW(MEMW),
    .LIR(LIR), .SELCTL(SELCTL), .S(S), .SEL(SEL), .STOP(STOP), .INTA(INTA)
  );

  always #5 T3 = ~T3;

  logic [24:0] obs;
  assign obs = {LDZ, LDC, CIN, M, DRW, ABUS, SBUS, MBUS, PCINC, PCADD, LPC, LAR,
                ARINC, MEMW, LIR, SELCTL, S, W[2:0], STOP, INTA};

  function automatic logic [24:0] mk(input logic [15:0] ctl, input logic [3:0] s,
                                     input logic [2:0] w, input logic stop, input logic inta);
    return {ctl, s, w, stop, inta};
  endfunction

  // expected beats of one instruction as seen from RUN W1
  task automatic exp_instr(input logic [3:0] op, input logic c, input logic z,
                           output int n, output logic [24:0] e0, output logic [24:0] e1);
    n  = 1;
    e1 = '0;
    case (op)
      4'h1: e0 = mk(B_CIN | B_ABUS | B_DRW | B_LDZ | B_LDC | FETCH, 4'b1001, 3'b001, 0, 0);
      4'h2: e0 = mk(B_ABUS | B_DRW | B_LDZ | B_LDC | FETCH, 4'b0110, 3'b001, 0, 0);
      4'h3: e0 = mk(B_M | B_ABUS | B_DRW | B_LDZ | FETCH, 4'b1011, 3'b001, 0, 0);
      4'h4: e0 = mk(B_ABUS | B_DRW | B_LDZ | B_LDC | FETCH, 4'b0000, 3'b001, 0, 0);
      4'hB: e0 = mk(B_M | B_ABUS | B_DRW | B_LDZ | FETCH, 4'b1110, 3'b001, 0, 0);
      4'hC: e0 = mk(B_M | B_ABUS | B_DRW | B_LDZ | FETCH, 4'b0110, 3'b001, 0, 0);
      4'hA: e0 = mk(B_M | B_ABUS | FETCH, 4'b1010, 3'b001, 0, 0);
      4'h9: begin
        n = 2;
        e0 = mk(B_M | B_ABUS | B_LPC, 4'b1111, 3'b001, 0, 0);
        e1 = mk(FETCH, 4'b0000, 3'b010, 0, 0);
      end
      4'h5: begin
        n = 2;
        e0 = mk(B_M | B_ABUS | B_LAR, 4'b1010, 3'b001, 0, 0);
        e1 = mk(B_MBUS | B_DRW | FETCH, 4'b0000, 3'b010, 0, 0);
      end
      4'h6: begin
        n = 2;
        e0 = mk(B_M | B_ABUS | B_LAR, 4'b1111, 3'b001, 0, 0);
        e1 = mk(B_M | B_ABUS | B_MEMW | FETCH, 4'b1010, 3'b010, 0, 0);
      end
      4'h7, 4'h8: begin
        if ((op == 4'h7 && c) || (op == 4'h8 && z)) begin
          n = 2;
          e0 = mk(B_PCADD, 4'b0000, 3'b001, 0, 0);
          e1 = mk(FETCH, 4'b0000, 3'b010, 0, 0);
        end else begin
          e0 = mk(FETCH, 4'b0000, 3'b001, 0, 0);
        end
      end
      4'hE: e0 = mk(16'h0000, 4'b0000, 3'b001, 1, 0);
      default: e0 = mk(FETCH, 4'b0000, 3'b001, 0, 0);
    endcase
  endtask

  task automatic tick();
    @(negedge T3);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (obs !== mk(0, 0, 0, 1, 0)) begin n_fail++; $display("FAIL reset_outputs got=%h exp=%h", obs, mk(0, 0, 0, 1, 0)); end
    n_checks++;
    if (SEL !== 4'h0) begin n_fail++; $display("FAIL reset_sel got=%h exp=0", SEL); end
    START = 1'b1;
    tick();
    START = 1'b0;
    n_checks++;
    if (obs !== mk(0, 0, 0, 1, 0)) begin n_fail++; $display("FAIL reset_hold got=%h exp=%h", obs, mk(0, 0, 0, 1, 0)); end
    CLR = 1'b1;
  endtask

  task automatic test_console_wreg();
    int r;
    logic [1:0] rr;
    SW = 3'b100; START = 1'b1;
    #1;
    n_checks++;
    if (obs !== mk(0, 0, 0, 1, 0)) begin n_fail++; $display("FAIL wreg_idle got=%h exp=%h", obs, mk(0, 0, 0, 1, 0)); end
    tick(); START = 1'b0;
    #1;
    n_checks++;
    if (obs !== mk(0, 0, 3'b001, 1, 0)) begin n_fail++; $display("FAIL wreg_wait got=%h exp=%h", obs, mk(0, 0, 3'b001, 1, 0)); end
    r = 0;
    for (int k = 0; k < 5; k++) begin
      START = 1'b1;
      rr = 2'(r);
      #1;
      n_checks++;
      if (SEL !== {rr, rr}) begin n_fail++; $display("FAIL wreg_sel step=%0d got=%h exp=%h", k, SEL, {rr, rr}); end
      n_checks++;
      if (obs !== mk(B_SBUS | B_DRW | B_SELCTL, 0, 3'b001, 1, 0)) begin
        n_fail++; $display("FAIL wreg_ctl step=%0d got=%h exp=%h", k, obs, mk(B_SBUS | B_DRW | B_SELCTL, 0, 3'b001, 1, 0));
      end
      tick(); START = 1'b0;
      r = (r + 1) % 4;
    end
    SW = 3'b000; START = 1'b1;
    #1;
    n_checks++;
    if (obs !== mk(0, 0, 3'b001, 1, 0)) begin n_fail++; $display("FAIL wreg_exit_noop got=%h exp=%h", obs, mk(0, 0, 3'b001, 1, 0)); end
    tick(); START = 1'b0;
    #1;
    n_checks++;
    if (obs !== mk(0, 0, 0, 1, 0)) begin n_fail++; $display("FAIL wreg_exit_idle got=%h exp=%h", obs, mk(0, 0, 0, 1, 0)); end
  endtask

  task automatic test_console_rreg();
    int r, steps;
    logic [1:0] ra, rb;
    SW = 3'b011; START = 1'b1;
    tick(); START = 1'b0;
    r = 0;
    steps = int'($urandom_range(3, 6));
    for (int k = 0; k < steps; k++) begin
      START = 1'b1;
      ra = 2'(r); rb = 2'(r + 1);
      #1;
      n_checks++;
      if (SEL !== {ra, rb} || obs !== mk(B_SELCTL, 0, 3'b001, 1, 0)) begin
        n_fail++; $display("FAIL rreg step=%0d got sel=%h ctl=%h exp sel=%h ctl=%h", k, SEL, obs, {ra, rb}, mk(B_SELCTL, 0, 3'b001, 1, 0));
      end
      tick(); START = 1'b0;
      r = (r + 2) % 4;
    end
    SW = 3'b111; START = 1'b1;
    tick(); START = 1'b0;
    #1;
    n_checks++;
    if (obs !== mk(0, 0, 0, 1, 0)) begin n_fail++; $display("FAIL rreg_exit got=%h exp=%h", obs, mk(0, 0, 0, 1, 0)); end
  endtask

  task automatic test_console_mem();
    SW = 3'b001; START = 1'b1;
    tick(); START = 1'b0;
    #1;
    n_checks++;
    if (obs !== mk(B_SBUS | B_LAR | B_SELCTL, 0, 3'b001, 0, 0)) begin
      n_fail++; $display("FAIL mem_setup got=%h exp=%h", obs, mk(B_SBUS | B_LAR | B_SELCTL, 0, 3'b001, 0, 0));
    end
    tick(); START = 1'b1;
    #1;
    n_checks++;
    if (obs !== mk(B_SBUS | B_MEMW | B_ARINC, 0, 3'b001, 1, 0)) begin
      n_fail++; $display("FAIL mem_write got=%h exp=%h", obs, mk(B_SBUS | B_MEMW | B_ARINC, 0, 3'b001, 1, 0));
    end
    tick(); START = 1'b0;
    SW = 3'b010; START = 1'b1;
    #1;
    n_checks++;
    if (obs !== mk(0, 0, 3'b001, 1, 0)) begin n_fail++; $display("FAIL mem_mismatch got=%h exp=%h", obs, mk(0, 0, 3'b001, 1, 0)); end
    tick(); START = 1'b0;
  endtask

  task automatic test_load();
    int n;
    logic [24:0] e0, e1;
    SW = 3'b000; START = 1'b1;
    tick(); START = 1'b0;
    #1;
    n_checks++;
    if (obs !== mk(B_SBUS | B_LPC | B_SELCTL, 0, 3'b001, 0, 0)) begin
      n_fail++; $display("FAIL setup_w1 got=%h exp=%h", obs, mk(B_SBUS | B_LPC | B_SELCTL, 0, 3'b001, 0, 0));
    end
    tick();
    n_checks++;
    if (obs !== mk(FETCH, 0, 3'b010, 0, 0)) begin n_fail++; $display("FAIL setup_w2 got=%h exp=%h", obs, mk(FETCH, 0, 3'b010, 0, 0)); end
    tick();
    IR = 4'h5;
    exp_instr(IR, C, Z, n, e0, e1);
    for (int b = 0; b < n; b++) begin
      #1;
      n_checks++;
      if (obs !== (b == 0 ? e0 : e1)) begin n_fail++; $display("FAIL load beat=%0d got=%h exp=%h", b, obs, (b == 0 ? e0 : e1)); end
      tick();
    end
  endtask

  task automatic test_run_random();
    int n;
    logic [24:0] e0, e1;
    for (int i = 0; i < 40; i++) begin
      IR = 4'($urandom_range(0, 15));
      if (IR == 4'hE) IR = 4'h0;
      C = 1'($urandom); Z = 1'($urandom);
      exp_instr(IR, C, Z, n, e0, e1);
      for (int b = 0; b < n; b++) begin
        #1;
        n_checks++;
        if (obs !== (b == 0 ? e0 : e1)) begin
          n_fail++; $display("FAIL run op=%h c=%0b z=%0b beat=%0d got=%h exp=%h", IR, C, Z, b, obs, (b == 0 ? e0 : e1));
        end
        tick();
      end
    end
  endtask

  task automatic test_branch();
    IR = 4'h7; C = 1'b1; Z = 1'b0;
    #1;
    n_checks++;
    if (obs !== mk(B_PCADD, 0, 3'b001, 0, 0)) begin n_fail++; $display("FAIL jc_taken_w1 got=%h exp=%h", obs, mk(B_PCADD, 0, 3'b001, 0, 0)); end
    tick();
    n_checks++;
    if (obs !== mk(FETCH, 0, 3'b010, 0, 0)) begin n_fail++; $display("FAIL jc_taken_w2 got=%h exp=%h", obs, mk(FETCH, 0, 3'b010, 0, 0)); end
    tick();
    C = 1'b0;
    #1;
    n_checks++;
    if (obs !== mk(FETCH, 0, 3'b001, 0, 0)) begin n_fail++; $display("FAIL jc_not_taken got=%h exp=%h", obs, mk(FETCH, 0, 3'b001, 0, 0)); end
    tick();
    n_checks++;
    if (W !== 3'b001) begin n_fail++; $display("FAIL jc_not_taken_next got=%b exp=001", W); end
  endtask

  task automatic test_sstep();
    IR = 4'h1; SSTEP = 1'b1;
    #1;
    n_checks++;
    if (obs !== mk(B_CIN | B_ABUS | B_DRW | B_LDZ | B_LDC | FETCH, 4'b1001, 3'b001, 0, 0)) begin
      n_fail++; $display("FAIL sstep_add got=%h exp=%h", obs, mk(B_CIN | B_ABUS | B_DRW | B_LDZ | B_LDC | FETCH, 4'b1001, 3'b001, 0, 0));
    end
    tick(); SSTEP = 1'b0;
    n_checks++;
    if (obs !== mk(0, 0, 0, 1, 0)) begin n_fail++; $display("FAIL sstep_halt got=%h exp=%h", obs, mk(0, 0, 0, 1, 0)); end
    tick();
    n_checks++;
    if (obs !== mk(0, 0, 0, 1, 0)) begin n_fail++; $display("FAIL sstep_halt_hold got=%h exp=%h", obs, mk(0, 0, 0, 1, 0)); end
    START = 1'b1;
    tick(); START = 1'b0;
    IR = 4'h2;
    #1;
    n_checks++;
    if (obs !== mk(B_ABUS | B_DRW | B_LDZ | B_LDC | FETCH, 4'b0110, 3'b001, 0, 0)) begin
      n_fail++; $display("FAIL sstep_resume got=%h exp=%h", obs, mk(B_ABUS | B_DRW | B_LDZ | B_LDC | FETCH, 4'b0110, 3'b001, 0, 0));
    end
    tick();
  endtask

  task automatic test_stp();
    IR = 4'hE;
    #1;
    n_checks++;
    if (obs !== mk(0, 0, 3'b001, 1, 0)) begin n_fail++; $display("FAIL stp_w1 got=%h exp=%h", obs, mk(0, 0, 3'b001, 1, 0)); end
    tick();
    n_checks++;
    if (obs !== mk(0, 0, 0, 1, 0)) begin n_fail++; $display("FAIL stp_halt got=%h exp=%h", obs, mk(0, 0, 0, 1, 0)); end
    START = 1'b1;
    tick(); START = 1'b0;
    IR = 4'h0;
    #1;
    n_checks++;
    if (obs !== mk(FETCH, 0, 3'b001, 0, 0)) begin n_fail++; $display("FAIL stp_resume got=%h exp=%h", obs, mk(FETCH, 0, 3'b001, 0, 0)); end
    tick();
  endtask

  task automatic test_interrupt();
    IR = 4'hF;
    tick();
    IR = 4'h1; INTR = 1'b1;
    tick();
    n_checks++;
    if (obs !== mk(B_LPC, 0, 3'b001, 0, 1)) begin n_fail++; $display("FAIL inta_w1 got=%h exp=%h", obs, mk(B_LPC, 0, 3'b001, 0, 1)); end
    tick();
    n_checks++;
    if (obs !== mk(FETCH, 0, 3'b010, 0, 0)) begin n_fail++; $display("FAIL inta_w2 got=%h exp=%h", obs, mk(FETCH, 0, 3'b010, 0, 0)); end
    tick();
    tick();
    IR = 4'h0;
    #1;
    n_checks++;
    if (obs !== mk(FETCH, 0, 3'b001, 0, 0)) begin n_fail++; $display("FAIL inta_second_ignored got=%h exp=%h", obs, mk(FETCH, 0, 3'b001, 0, 0)); end
    INTR = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    IR = 4'hF;
    tick();
    IR = 4'h6;
    tick();
    n_checks++;
    if (MEMW !== 1'b1) begin n_fail++; $display("FAIL st_w2_memw got=%b exp=1", MEMW); end
    CLR = 1'b0;
    #1;
    n_checks++;
    if (obs !== mk(0, 0, 0, 1, 0)) begin n_fail++; $display("FAIL reset_mid_abort got=%h exp=%h", obs, mk(0, 0, 0, 1, 0)); end
    tick(); tick();
    CLR = 1'b1;
    #1;
    n_checks++;
    if (obs !== mk(0, 0, 0, 1, 0)) begin n_fail++; $display("FAIL reset_mid_release got=%h exp=%h", obs, mk(0, 0, 0, 1, 0)); end
    SW = 3'b000; START = 1'b1;
    tick(); START = 1'b0;
    tick(); tick();
    IR = 4'h0; INTR = 1'b1;
    tick();
    n_checks++;
    if (obs !== mk(FETCH, 0, 3'b001, 0, 0)) begin n_fail++; $display("FAIL reset_mid_ie_cleared got=%h exp=%h", obs, mk(FETCH, 0, 3'b001, 0, 0)); end
    INTR = 1'b0;
  endtask

  initial begin
    CLR = 1'b0; START = 1'b0; SSTEP = 1'b0; INTR = 1'b0;
    C = 1'b0; Z = 1'b0; SW = 3'b000; IR = 4'h0;
    test_reset();
    test_console_wreg();
    test_console_rreg();
    test_console_mem();
    test_load();
    test_run_random();
    test_branch();
    test_sstep();
    test_stp();
    test_interrupt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
